// File: rtl/dbg_step_ctrl.sv
// dbg_step_ctrl: single-step / burst / free-run clock-enable controller for a
// debug front panel, with cycle counter and a registered display mux.
// Optional macro DBG_BREAKPOINT_EN adds a PC breakpoint that parks the
// controller in BRK before the instruction at the breakpoint address executes.
module dbg_step_ctrl #(
  parameter int CNT_W   = 16,
  parameter int PC_W    = 32,
  parameter int BURST_W = 8,
  parameter int NCH     = 4
) (
  input  logic                     clk,
  input  logic                     RSTN,
  input  logic                     step_btn,
  input  logic                     run_sw,
  input  logic [BURST_W-1:0]       burst_len,
  input  logic [PC_W-1:0]          pc,
  input  logic                     bp_en,
  input  logic [PC_W-1:0]          bp_addr,
  input  logic                     cnt_clr,
  input  logic [$clog2(NCH)-1:0]   sel,
  input  logic [16*NCH-1:0]        ch_data,
  output logic                     cpu_en,
  output logic [CNT_W-1:0]         cyc_cnt,
  output logic [2:0]               state,
  output logic [15:0]              disp_num
);

  typedef enum logic [2:0] {
    S_HALT  = 3'd0,
    S_STEP  = 3'd1,
    S_BURST = 3'd2,
    S_RUN   = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [BURST_W-1:0] r_remaining;
  logic [BURST_W-1:0] w_remaining_next;
  logic               r_step_prev;
  logic               w_step_edge;
  logic               w_bp_hit;
  logic               w_active;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_disp;
  logic [15:0]        w_disp_sel;

  assign w_step_edge = step_btn & ~r_step_prev;
  assign w_active    = (r_state == S_STEP) || (r_state == S_BURST) || (r_state == S_RUN);
  assign cpu_en      = w_active & ~w_bp_hit;
  assign cyc_cnt     = r_cnt;
  assign state       = r_state;
  assign disp_num    = r_disp;

`ifdef DBG_BREAKPOINT_EN
  logic [PC_W-1:0] r_resume_pc;
  logic            r_moved;
  logic            w_enter;
  logic            w_free;

  // Breakpoint only after the PC has left the resume point, so a resume from
  // BRK can step past the breakpoint it stopped on.
  assign w_free   = (r_state == S_RUN) || (r_state == S_BURST);
  assign w_bp_hit = bp_en & r_moved & (pc == bp_addr) & w_free;
  assign w_enter  = ((w_next == S_RUN) && (r_state != S_RUN)) ||
                    ((w_next == S_BURST) && (r_state != S_BURST));

  // Capture the resume PC on entry to RUN/BURST and track departure from it.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_resume_pc <= '0;
      r_moved     <= 1'b0;
    end else if (w_enter) begin
      r_resume_pc <= pc;
      r_moved     <= 1'b0;
    end else if (w_free && (pc != r_resume_pc)) begin
      r_moved     <= 1'b1;
    end
  end
`else
  logic w_unused_bp;

  assign w_bp_hit    = 1'b0;
  assign w_unused_bp = ^{bp_en, bp_addr, pc};
`endif

  // State, burst counter and step-button history registers.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= S_HALT;
      r_remaining <= '0;
      r_step_prev <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_remaining <= w_remaining_next;
      r_step_prev <= step_btn;
    end
  end

  // Next-state logic; a breakpoint hit overrides everything in RUN/BURST.
  always_comb begin
    w_next           = r_state;
    w_remaining_next = r_remaining;
    case (r_state)
      S_HALT: begin
        if (run_sw) begin
          w_next = S_RUN;
        end else if (w_step_edge) begin
          if (burst_len == '0) begin
            w_next = S_STEP;
          end else begin
            w_next           = S_BURST;
            w_remaining_next = burst_len;
          end
        end
      end
      S_STEP: begin
        w_next = S_HALT;
      end
      S_BURST: begin
        if (w_bp_hit) begin
          w_next = S_BRK;
        end else begin
          w_remaining_next = r_remaining - BURST_W'(1);
          if (r_remaining <= BURST_W'(1)) begin
            w_next = S_HALT;
          end
        end
      end
      S_RUN: begin
        if (w_bp_hit) begin
          w_next = S_BRK;
        end else if (!run_sw) begin
          w_next = S_HALT;
        end
      end
      S_BRK: begin
        if (w_step_edge) begin
          w_next = S_STEP;
        end else if (!run_sw) begin
          w_next = S_HALT;
        end
      end
      default: begin
        w_next = S_HALT;
      end
    endcase
  end

  // Count issued enables; clear has priority over the increment.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (cpu_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Channel select; out-of-range selects fall back to channel 0.
  always_comb begin
    w_disp_sel = ch_data[15:0];
    if (int'(sel) < NCH) begin
      w_disp_sel = ch_data[16*int'(sel) +: 16];
    end
  end

  // Register the selected display channel.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_disp <= '0;
    end else begin
      r_disp <= w_disp_sel;
    end
  end

endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Testbench for dbg_step_ctrl: directed scenarios with literal expectations,
// then randomized stimulus, all checked every cycle against a behavioural
// model. A second instance (CNT_W=4, NCH=3) exercises counter wrap and the
// out-of-range channel select. Build with or without DBG_BREAKPOINT_EN.
module tb_dbg_step_ctrl;

  logic        clk = 1'b0;
  logic        RSTN = 1'b0;
  logic        step_btn = 1'b0;
  logic        run_sw = 1'b0;
  logic [7:0]  burst_len = '0;
  logic [31:0] pc = '0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic        cnt_clr = 1'b0;
  logic [1:0]  sel = '0;
  logic [63:0] ch_data = '0;

  logic        cpu_en, cpu_en4;
  logic [15:0] cyc_cnt;
  logic [3:0]  cyc_cnt4;
  logic [2:0]  state, state4;
  logic [15:0] disp_num, disp3;

  int n_tests = 0;
  int n_fail  = 0;

  // snapshot of DUT outputs taken by step_cycle
  logic        s_en;
  logic [2:0]  s_state;
  logic [15:0] s_cnt;
  logic [3:0]  s_cnt4;
  logic [15:0] s_disp, s_disp3;

  // behavioural model
  int          m_state = 0;
  int          m_rem = 0;
  int          m_cnt = 0;
  bit          m_prev = 0;
  bit          m_moved = 0;
  logic [31:0] m_rpc = '0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_disp3 = '0;

  always #5 clk = ~clk;

  dbg_step_ctrl u_dut (
    .clk(clk), .RSTN(RSTN), .step_btn(step_btn), .run_sw(run_sw),
    .burst_len(burst_len), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .cnt_clr(cnt_clr), .sel(sel), .ch_data(ch_data),
    .cpu_en(cpu_en), .cyc_cnt(cyc_cnt), .state(state), .disp_num(disp_num)
  );

  dbg_step_ctrl #(.CNT_W(4), .NCH(3)) u_dut4 (
    .clk(clk), .RSTN(RSTN), .step_btn(step_btn), .run_sw(run_sw),
    .burst_len(burst_len), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .cnt_clr(cnt_clr), .sel(sel), .ch_data(ch_data[47:0]),
    .cpu_en(cpu_en4), .cyc_cnt(cyc_cnt4), .state(state4), .disp_num(disp3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: model outputs for this cycle, then advance the model.
  always @(negedge clk) begin : compare
    bit   hit, en, stp;
    int   ns;
    if (!RSTN) begin
      m_state = 0; m_rem = 0; m_cnt = 0; m_prev = 0; m_moved = 0;
      m_rpc = '0; m_disp = '0; m_disp3 = '0;
    end
    hit = 0;
`ifdef DBG_BREAKPOINT_EN
    hit = bp_en && m_moved && (pc == bp_addr) && (m_state == 2 || m_state == 3);
`endif
    en = (m_state >= 1 && m_state <= 3) && !hit;
    check("m_state", state, m_state);
    check("m_cpu_en", cpu_en, en);
    check("m_cyc_cnt", cyc_cnt, m_cnt % 65536);
    check("m_disp", disp_num, m_disp);
    check("m_state4", state4, m_state);
    check("m_cpu_en4", cpu_en4, en);
    check("m_cyc_cnt4", cyc_cnt4, m_cnt % 16);
    check("m_disp3", disp3, m_disp3);
    if (RSTN) begin
      stp = step_btn && !m_prev;
      ns = m_state;
      case (m_state)
        0: if (run_sw) ns = 3;
           else if (stp) begin
             if (burst_len == 0) ns = 1;
             else begin ns = 2; m_rem = burst_len; end
           end
        1: ns = 0;
        2: if (hit) ns = 4;
           else begin m_rem = m_rem - 1; if (m_rem == 0) ns = 0; end
        3: if (hit) ns = 4; else if (!run_sw) ns = 0;
        4: if (stp) ns = 1; else if (!run_sw) ns = 0;
        default: ns = 0;
      endcase
      if ((ns == 2 || ns == 3) && ns != m_state) begin
        m_rpc = pc; m_moved = 0;
      end else if ((m_state == 2 || m_state == 3) && pc != m_rpc) begin
        m_moved = 1;
      end
      m_state = ns;
      if (cnt_clr) m_cnt = 0;
      else if (en) m_cnt = (m_cnt + 1) % 65536;
      m_prev = step_btn;
      m_disp  = ch_data[int'(sel)*16 +: 16];
      m_disp3 = (sel < 3) ? ch_data[int'(sel)*16 +: 16] : ch_data[15:0];
    end
  end

  // One clock: snapshot outputs mid-cycle, then advance the CPU PC on enable.
  task automatic step_cycle();
    @(negedge clk);
    s_en = cpu_en; s_state = state; s_cnt = cyc_cnt; s_cnt4 = cyc_cnt4;
    s_disp = disp_num; s_disp3 = disp3;
    @(posedge clk);
    #1;
    if (s_en) pc = (pc + 32'd4) & 32'h1F;
  endtask

  initial begin : stim
    int n, first, last;
    bit found;

    // reset
    step_cycle(); step_cycle();
    check("rst_state", s_state, 0);
    check("rst_en", s_en, 0);
    check("rst_cnt", s_cnt, 0);
    check("rst_disp", s_disp, 0);
    RSTN = 1'b1;

    // single step
    step_btn = 1'b1; step_cycle();
    check("step_pre_state", s_state, 0);
    step_btn = 1'b0; step_cycle();
    check("step_state", s_state, 1);
    check("step_en", s_en, 1);
    step_cycle();
    check("step_done_state", s_state, 0);
    check("step_done_en", s_en, 0);
    check("step_cnt", s_cnt, 1);

    // burst of 5 with run_sw pulse mid-burst
    burst_len = 8'd5; step_btn = 1'b1; cnt_clr = 1'b1; step_cycle();
    step_btn = 1'b0; cnt_clr = 1'b0;
    n = 0; first = -1; last = -1;
    for (int i = 0; i < 10; i++) begin
      run_sw = (i == 2);
      step_cycle();
      if (s_en) begin n++; if (first < 0) first = i; last = i; end
    end
    check("burst_count", n, 5);
    check("burst_span", last - first, 4);
    check("burst_cnt", s_cnt, 5);
    check("burst_state", s_state, 0);

    // counter wrap on the 4-bit instance
    cnt_clr = 1'b1; step_cycle(); cnt_clr = 1'b0;
    run_sw = 1'b1; step_cycle();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) run_sw = 1'b0;
      step_cycle();
      if (s_en) n++;
    end
    check("run_count", n, 16);
    step_cycle();
    check("wrap_cnt4", s_cnt4, 0);
    check("wrap_cnt16", s_cnt, 16);
    check("run_halt", s_state, 0);

    // clear wins over increment
    run_sw = 1'b1; step_cycle(); step_cycle(); step_cycle();
    cnt_clr = 1'b1; step_cycle();
    check("clr_en_high", s_en, 1);
    cnt_clr = 1'b0; run_sw = 1'b0; step_cycle();
    check("clr_cnt", s_cnt, 0);
    check("clr_cnt4", s_cnt4, 0);
    step_cycle();

`ifdef DBG_BREAKPOINT_EN
    // breakpoint at 0xC while running from 0
    pc = 32'h0; bp_en = 1'b1; bp_addr = 32'hC; run_sw = 1'b1; step_cycle();
    found = 0;
    for (int i = 0; i < 12; i++) begin
      step_cycle();
      if (s_state == 3'd3 && !s_en) begin found = 1; break; end
    end
    check("bp_stop", found, 1);
    check("bp_pc", pc, 32'hC);
    step_cycle();
    check("brk_state", s_state, 4);
    check("brk_en", s_en, 0);
    run_sw = 1'b0; step_btn = 1'b1; step_cycle();
    check("brk_edge_state", s_state, 4);
    step_btn = 1'b0; step_cycle();
    check("brk_step_state", s_state, 1);
    check("brk_step_en", s_en, 1);
    step_cycle();
    check("brk_halt", s_state, 0);
    bp_en = 1'b0;
`endif

    // display mux and reset mid-burst
    ch_data = 64'h0000_BEEF_5678_1234; sel = 2'd2; step_cycle(); step_cycle();
    check("disp_ch2", s_disp, 16'hBEEF);
    check("disp3_ch2", s_disp3, 16'hBEEF);
    sel = 2'd3; step_cycle(); step_cycle();
    check("disp_ch3", s_disp, 16'h0000);
    check("disp3_oor", s_disp3, 16'h1234);
    burst_len = 8'd7; step_btn = 1'b1; step_cycle();
    step_btn = 1'b0; step_cycle(); step_cycle();
    check("midburst_state", s_state, 2);
    RSTN = 1'b0; step_cycle();
    check("arst_state", s_state, 0);
    check("arst_en", s_en, 0);
    check("arst_cnt", s_cnt, 0);
    check("arst_disp", s_disp, 0);
    RSTN = 1'b1; n = 0;
    for (int i = 0; i < 5; i++) begin step_cycle(); if (s_en) n++; end
    check("arst_no_en", n, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RSTN = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 15) == 0) run_sw = ~run_sw;
      burst_len = 8'($urandom_range(0, 6));
      bp_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) bp_addr = 32'($urandom_range(0, 7)) << 2;
      cnt_clr = ($urandom_range(0, 39) == 0);
      sel = 2'($urandom);
      ch_data = {$urandom, $urandom};
      if ($urandom_range(0, 29) == 0) pc = 32'($urandom_range(0, 7)) << 2;
      step_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
